// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with one-cycle ops and optional iterative multiply (ALU_SEQ_MUL_EN)
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ofl,
    output logic             err
);
    localparam int SHW = $clog2(WIDTH);
    localparam int HW = WIDTH / 2;
    localparam logic [SHW:0] WV = WIDTH[SHW:0];

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE, DONE, MUL} state_t;
`else
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

    state_t state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic ofl_q, ofl_d, err_q, err_d;
    logic accept;
    logic [WIDTH:0] sum;
    logic [WIDTH-1:0] diff, rol, ror, btr, alu_r;
    logic [SHW-1:0] sh;
    logic [SHW:0] inv;
    logic lt, eq, sovf_add, sovf_sub, alu_o, alu_e;

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [SHW:0] cnt_q, cnt_d;
`endif

    assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept = in_valid && in_ready;
    assign out_valid = state_q == DONE;
    assign result = result_q;
    assign ofl = ofl_q;
    assign err = err_q;

    assign sum = {1'b0, a} + {1'b0, b};
    assign diff = a - b;
    assign sh = b[SHW-1:0];
    // complementary shift is WIDTH-sh; at sh=0 it shifts everything out, leaving a unchanged
    assign inv = WV - {1'b0, sh};
    assign rol = (a << sh) | (a >> inv);
    assign ror = (a >> sh) | (a << inv);
    assign eq = a == b;
    assign lt = sign ? ($signed(a) < $signed(b)) : (a < b);
    assign sovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    for (genvar i = 0; i < WIDTH; i++) begin : g_btr
        assign btr[i] = a[WIDTH-1-i];
    end

    // single-cycle operation results and flags
    always_comb begin
        alu_r = '0;
        alu_o = 1'b0;
        alu_e = 1'b0;
        case (op)
            4'd0: begin alu_r = sum[WIDTH-1:0]; alu_o = sign ? sovf_add : sum[WIDTH]; end
            4'd1: begin alu_r = diff; alu_o = sign ? sovf_sub : (a < b); end
            4'd2: alu_r = a ^ b;
            4'd3: alu_r = a & ~b;
            4'd4: alu_r = rol;
            4'd5: alu_r = a << sh;
            4'd6: alu_r = ror;
            4'd7: alu_r = a >> sh;
            4'd8: alu_r = {{(WIDTH-1){1'b0}}, eq};
            4'd9: alu_r = {{(WIDTH-1){1'b0}}, lt};
            4'd10: alu_r = {{(WIDTH-1){1'b0}}, lt | eq};
            4'd11: alu_r = {{(WIDTH-1){1'b0}}, sum[WIDTH]};
            4'd12: alu_r = {a[HW-1:0], b[HW-1:0]};
            4'd13: alu_r = btr;
            default: alu_e = 1'b1;
        endcase
    end

    // handshake FSM next state, result capture and multiply iteration
    always_comb begin
        state_d = state_q;
        result_d = result_q;
        ofl_d = ofl_q;
        err_d = err_q;
`ifdef ALU_SEQ_MUL_EN
        acc_d = acc_q;
        mcand_d = mcand_q;
        mplier_d = mplier_q;
        cnt_d = cnt_q;
        if (state_q == MUL) begin
            if (cnt_q == WV) begin
                state_d = DONE;
                result_d = acc_q[WIDTH-1:0];
                ofl_d = |acc_q[2*WIDTH-1:WIDTH];
                err_d = 1'b0;
            end else begin
                acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d = cnt_q + (SHW+1)'(1);
            end
        end
`endif
        if (accept) begin
            state_d = DONE;
            result_d = alu_r;
            ofl_d = alu_o;
            err_d = alu_e;
`ifdef ALU_SEQ_MUL_EN
            if (op == 4'd14) begin
                state_d = MUL;
                acc_d = '0;
                mcand_d = {{WIDTH{1'b0}}, a};
                mplier_d = b;
                cnt_d = '0;
            end
`endif
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    // state registers; reset abandons any multiply in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            result_q <= '0;
            ofl_q <= 1'b0;
            err_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q <= '0;
            mcand_q <= '0;
            mplier_q <= '0;
            cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            result_q <= result_d;
            ofl_q <= ofl_d;
            err_q <= err_d;
`ifdef ALU_SEQ_MUL_EN
            acc_q <= acc_d;
            mcand_q <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector scoreboard bench for alu_seq (WIDTH=16, honours ALU_SEQ_MUL_EN)
module tb_alu_seq;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int MUL_LAT = MUL_EN ? 17 : 1;

    typedef struct packed {
        logic [15:0] r;
        logic o;
        logic e;
    } exp_t;

    logic clk, rst_n, in_valid, in_ready, sign, out_valid, out_ready, ofl, err;
    logic [3:0] op;
    logic [15:0] a, b, result;
    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .sign(sign), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .ofl(ofl), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor: every transferred result is checked against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                chk("result", 32'(result), 32'(e.r));
                chk("ofl", 32'(ofl), 32'(e.o));
                chk("err", 32'(err), 32'(e.e));
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic s, input logic [15:0] er, input logic eo, input logic ee,
                         input int lat);
        int n;
        @(posedge clk);
        #1;
        op = o; a = x; b = y; sign = s; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 50) chk("accept_timeout", 32'd1, 32'd0);
        q.push_back('{er, eo, ee});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("latency_op%0d", o), 32'(n), 32'(lat));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; sign = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_ofl", 32'(ofl), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        issue(4'd0, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b0, 1);
        issue(4'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
        issue(4'd0, 16'h0002, 16'h0003, 1'b1, 16'h0005, 1'b0, 1'b0, 1);
        issue(4'd1, 16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1);
        issue(4'd1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1);
        issue(4'd1, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b0, 1'b0, 1);
        issue(4'd2, 16'h00FF, 16'h0F0F, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1);
        issue(4'd3, 16'hF0F0, 16'hFF00, 1'b0, 16'h00F0, 1'b0, 1'b0, 1);
        issue(4'd4, 16'h8001, 16'h0001, 1'b0, 16'h0003, 1'b0, 1'b0, 1);
        issue(4'd4, 16'h1234, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0, 1);
        issue(4'd5, 16'h0001, 16'h0011, 1'b0, 16'h0002, 1'b0, 1'b0, 1);
        issue(4'd6, 16'h0001, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1);
        issue(4'd6, 16'h1234, 16'h0010, 1'b0, 16'h1234, 1'b0, 1'b0, 1);
        issue(4'd7, 16'h8000, 16'h000F, 1'b0, 16'h0001, 1'b0, 1'b0, 1);
        issue(4'd8, 16'h1234, 16'h1234, 1'b0, 16'h0001, 1'b0, 1'b0, 1);
        issue(4'd8, 16'h1234, 16'h1235, 1'b0, 16'h0000, 1'b0, 1'b0, 1);
        issue(4'd9, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b0, 1);
        issue(4'd9, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1);
        issue(4'd10, 16'h0005, 16'h0005, 1'b0, 16'h0001, 1'b0, 1'b0, 1);
        issue(4'd10, 16'hFFFF, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1);
        issue(4'd10, 16'h0001, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1);
        issue(4'd11, 16'hFFFF, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0, 1);
        issue(4'd11, 16'h0001, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1);
        issue(4'd12, 16'h0012, 16'h00AB, 1'b0, 16'h12AB, 1'b0, 1'b0, 1);
        issue(4'd13, 16'h0001, 16'h0000, 1'b0, 16'h8000, 1'b0, 1'b0, 1);
        issue(4'd13, 16'h00F1, 16'h0000, 1'b0, 16'h8F00, 1'b0, 1'b0, 1);
        issue(4'd15, 16'h1234, 16'h5678, 1'b0, 16'h0000, 1'b0, 1'b1, 1);
        issue(4'd14, 16'h0100, 16'h0100, 1'b0, 16'h0000, MUL_EN, !MUL_EN, MUL_LAT);
        issue(4'd14, 16'h0003, 16'h0005, 1'b0, MUL_EN ? 16'h000F : 16'h0000, 1'b0, !MUL_EN, MUL_LAT);

        // stall: result must hold and no new op be taken while out_ready is low
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(4'd2, 16'h00FF, 16'h0F0F, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_result", 32'(result), 32'h0FF0);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        op = 4'd0; a = 16'h0001; b = 16'h0002; sign = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        q.push_back('{16'h0003, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_result", 32'(result), 32'h0003);

        // reset during a multiply abandons it
        @(posedge clk);
        #1;
        op = 4'd14; a = 16'h0003; b = 16'h0005; in_valid = 1'b1;
        if (!MUL_EN) q.push_back('{16'h0000, 1'b0, 1'b1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mulrst_out_valid", 32'(out_valid), 32'd0);
        chk("mulrst_result", 32'(result), 32'd0);
        chk("mulrst_in_ready", 32'(in_ready), 32'd1);
        chk("mulrst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("mulrst_no_output", 32'(out_valid), 32'd0);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
